// File: rtl/uart_rx_oversampled.sv
// UART receiver sampling rx at mid-bit on a 16x tick; frame result appears 1 clk after the mid-stop-bit tick.
// No backpressure: rx_done is a single-clk pulse and dout/frame_err hold until the next completed frame.
module uart_rx_oversampled #(
    parameter int NBITS    = 8,
    parameter int SB_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             rx,
    output logic [NBITS-1:0] dout,
    output logic             rx_done,
    output logic             frame_err
);

    localparam int              BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [3:0]      SB_LAST  = 4'(SB_TICKS - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         tick_cnt, tick_cnt_nxt;
    logic [BW-1:0]      bit_cnt, bit_cnt_nxt;
    logic [NBITS-1:0]   shreg, shreg_nxt;
    logic               rx_meta, rx_sync;
    logic               frame_end;

    // rx is asynchronous to clk; idle-high reset value keeps IDLE from seeing a false start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        unique case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt    = START;
                    tick_cnt_nxt = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt_nxt = '0;
                        // still low at mid start bit: genuine frame, otherwise a glitch
                        if (!rx_sync) begin
                            state_nxt   = DATA;
                            bit_cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt == 4'd15) begin
                        shreg_nxt    = {rx_sync, shreg[NBITS-1:1]};
                        tick_cnt_nxt = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt == SB_LAST) begin
                        state_nxt    = IDLE;
                        tick_cnt_nxt = '0;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_end = (state == STOP) && tick && (tick_cnt == SB_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_done   <= 1'b0;
            dout      <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_done <= frame_end;
            if (frame_end) begin
                dout      <= shreg;
                frame_err <= ~rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frames are driven bit by bit on tick counts and
// every rx_done is matched against a queue of expected (data, frame_err) results.
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;

    typedef struct {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_fe = 1'b0;
    logic       prev_done = 1'b0;
    bit         tick_en = 1'b1;
    int         errors = 0;
    int         checks = 0;
    int         n_done = 0;
    int         base;

    uart_rx_oversampled #(.NBITS(8), .SB_TICKS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .dout      (dout),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // one tick every 4 clks, gated by tick_en
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            tick = tick_en && (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
                if (guard > 4000) begin
                    errors++;
                    $display("FAIL tick_timeout: got no tick expected tick within 4000 clks");
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $fatal(1, "tick generator stalled");
                end
            end while (tick !== 1'b1);
        end
        @(negedge clk);
    endtask

    // start bit, 8 data bits LSB first, stop bit; optional 1000-clk tick freeze mid data bit
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int freeze_bit);
        exp_t e;
        e.d  = d;
        e.fe = ~stopv;
        expq.push_back(e);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == freeze_bit) begin
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (1000) @(negedge clk);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        rx = stopv;
        if (stopv) begin
            wait_ticks(16);
        end else begin
            // release a bad stop bit early so the receiver does not take it as a new start
            wait_ticks(10);
            rx = 1'b1;
            wait_ticks(6);
        end
        rx = 1'b1;
    endtask

    // continuous compare against the queue-based model, sampled 1 time unit after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rx_done === 1'b1) begin
                n_done++;
                chk("done_width", {31'd0, prev_done}, 32'd0);
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_done: got rx_done=1 expected no pending frame");
                end else begin
                    e = expq.pop_front();
                    m_dout = e.d;
                    m_fe = e.fe;
                end
            end
            chk("dout", {24'd0, dout}, {24'd0, m_dout});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
            prev_done = rx_done;
        end
    end

    initial begin
        rx = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_dout", {24'd0, dout}, 32'h0);
        chk("rst_done", {31'd0, rx_done}, 32'h0);
        chk("rst_ferr", {31'd0, frame_err}, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        base = n_done;
        send_frame(8'hA5, 1'b1, -1);
        wait_ticks(4);
        chk("a5_count", n_done - base, 32'd1);
        chk("a5_dout", {24'd0, dout}, 32'hA5);
        chk("a5_ferr", {31'd0, frame_err}, 32'h0);

        base = n_done;
        send_frame(8'h3C, 1'b0, -1);
        wait_ticks(4);
        chk("3c_count", n_done - base, 32'd1);
        chk("3c_dout", {24'd0, dout}, 32'h3C);
        chk("3c_ferr", {31'd0, frame_err}, 32'h1);
        send_frame(8'h11, 1'b1, -1);
        wait_ticks(4);
        chk("11_dout", {24'd0, dout}, 32'h11);
        chk("11_ferr", {31'd0, frame_err}, 32'h0);

        base = n_done;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        chk("glitch_count", n_done - base, 32'd0);
        chk("glitch_dout", {24'd0, dout}, 32'h11);

        base = n_done;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        wait_ticks(4);
        chk("b2b_count", n_done - base, 32'd2);
        chk("b2b_dout", {24'd0, dout}, 32'hFF);
        chk("b2b_pending", expq.size(), 32'd0);

        base = n_done;
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            wait_ticks(16);
        end
        rx = 1'b0;
        wait_ticks(8);
        expq.delete();
        m_dout = 8'h00;
        m_fe = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_dout", {24'd0, dout}, 32'h0);
        chk("async_rst_done", {31'd0, rx_done}, 32'h0);
        chk("async_rst_ferr", {31'd0, frame_err}, 32'h0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        wait_ticks(200);
        chk("rst_abort_count", n_done - base, 32'd0);
        send_frame(8'h5A, 1'b1, -1);
        wait_ticks(4);
        chk("5a_count", n_done - base, 32'd1);
        chk("5a_dout", {24'd0, dout}, 32'h5A);

        base = n_done;
        send_frame(8'h96, 1'b1, 4);
        wait_ticks(4);
        chk("freeze_count", n_done - base, 32'd1);
        chk("freeze_dout", {24'd0, dout}, 32'h96);
        chk("freeze_ferr", {31'd0, frame_err}, 32'h0);

        wait_ticks(40);
        chk("final_pending", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
